// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall sequencer for the five-stage pipeline: load-use stall,
// branch/jump redirect and flush, data-memory freeze with timeout, perf counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_memtoreg,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic [1:0]       pc_sel,
  output logic             stall,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  localparam logic [1:0] SEL_PC4    = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JUMP   = 2'b10;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERROR
  } state_e;

  state_e           state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic freeze;
  logic load_use;
  logic rs_hit;
  logic rt_hit;

  assign freeze   = (state_q != ERROR) && mem_req && !dmem_ready;
  assign rs_hit   = id_uses_rs && (id_rs == ex_rd);
  assign rt_hit   = id_uses_rt && (id_rt == ex_rd);
  assign load_use = ex_memtoreg && (ex_rd != '0) && (rs_hit || rt_hit);

  // Outputs follow the state and inputs combinationally; reset overrides everything.
  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    pc_sel       = SEL_PC4;
    stall        = 1'b0;
    if (!rst_n) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
    end else if (state_q == ERROR || freeze) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
      stall        = 1'b1;
    end else if (ex_branch_taken) begin
      // Both younger instructions are wrong-path, so load-use and jump are moot.
      pc_sel     = SEL_BRANCH;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      stall      = 1'b1;
    end else if (id_jump) begin
      pc_sel     = SEL_JUMP;
      ifid_flush = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    unique case (state_q)
      RUN: begin
        if (freeze) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (freeze) begin
          if (wait_cnt_q == WAIT_LAST) begin
            state_d   = ERROR;
            mem_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end else begin
          state_d = RUN;
        end
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (state_q != ERROR) begin
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (ifid_flush && (flush_cnt_q != '1)) begin
        flush_cnt_d = flush_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed checks of pipeline_hazard_ctrl against a rule-level model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned TO   = 4;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    id_rs = '0, id_rt = '0, ex_rd = '0;
  logic          id_uses_rs = 1'b0, id_uses_rt = 1'b0, id_jump = 1'b0;
  logic          ex_memtoreg = 1'b0, ex_branch_taken = 1'b0;
  logic          mem_req = 1'b0, dmem_ready = 1'b1;
  logic          pc_en, ifid_en, idex_en, exmem_en;
  logic          ifid_flush, idex_flush, memwb_bubble, stall, mem_err;
  logic [1:0]    pc_sel;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int tests = 0;
  int fails = 0;

  pipeline_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .ex_memtoreg(ex_memtoreg), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_bubble(memwb_bubble),
    .pc_sel(pc_sel), .stall(stall), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_en, ifid_en, idex_en, exmem_en;
    logic       ifid_flush, idex_flush, memwb_bubble;
    logic [1:0] pc_sel;
    logic       stall;
  } exp_t;

  // Model state: error flag, length of the current freeze run, event counts.
  int m_err = 0;
  int m_run = 0;
  int m_stall = 0;
  int m_flush = 0;

  function automatic exp_t calc(input logic rst, input int err);
    exp_t e;
    logic lu;
    e = '{pc_en:1, ifid_en:1, idex_en:1, exmem_en:1, ifid_flush:0, idex_flush:0,
          memwb_bubble:0, pc_sel:2'd0, stall:0};
    lu = ex_memtoreg && ex_rd != 0 &&
         ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    if (!rst)
      e = '{pc_en:0, ifid_en:0, idex_en:0, exmem_en:0, ifid_flush:1, idex_flush:1,
            memwb_bubble:1, pc_sel:2'd0, stall:0};
    else if (err != 0 || (mem_req && !dmem_ready))
      e = '{pc_en:0, ifid_en:0, idex_en:0, exmem_en:0, ifid_flush:0, idex_flush:0,
            memwb_bubble:1, pc_sel:2'd0, stall:1};
    else if (ex_branch_taken) begin
      e.pc_sel = 2'd1; e.ifid_flush = 1; e.idex_flush = 1;
    end else if (lu) begin
      e.pc_en = 0; e.ifid_en = 0; e.idex_flush = 1; e.stall = 1;
    end else if (id_jump) begin
      e.pc_sel = 2'd2; e.ifid_flush = 1;
    end
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    e = calc(rst_n, m_err);
    if (!rst_n) begin
      m_err <= 0; m_run <= 0; m_stall <= 0; m_flush <= 0;
    end else if (m_err == 0) begin
      if (e.stall && m_stall < CMAX) m_stall <= m_stall + 1;
      if (e.ifid_flush && m_flush < CMAX) m_flush <= m_flush + 1;
      if (mem_req && !dmem_ready) begin
        m_run <= m_run + 1;
        if (m_run + 1 == TO + 1) m_err <= 1;
      end else begin
        m_run <= 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    e = calc(rst_n, m_err);
    check("pc_en", pc_en, e.pc_en);
    check("ifid_en", ifid_en, e.ifid_en);
    check("idex_en", idex_en, e.idex_en);
    check("exmem_en", exmem_en, e.exmem_en);
    check("ifid_flush", ifid_flush, e.ifid_flush);
    check("idex_flush", idex_flush, e.idex_flush);
    check("memwb_bubble", memwb_bubble, e.memwb_bubble);
    check("pc_sel", pc_sel, e.pc_sel);
    check("stall", stall, e.stall);
    check("mem_err", mem_err, rst_n ? m_err : 0);
    check("stall_cnt", stall_cnt, rst_n ? m_stall : 0);
    check("flush_cnt", flush_cnt, rst_n ? m_flush : 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; ex_rd = '0;
    id_uses_rs = 0; id_uses_rt = 0; id_jump = 0;
    ex_memtoreg = 0; ex_branch_taken = 0;
    mem_req = 0; dmem_ready = 1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    step(); step();
    rst_n = 1;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    ex_memtoreg = 1; ex_rd = rd; id_rs = 5'd8; id_uses_rs = 1;
  endtask

  initial begin
    #1;
    check("reset_stall", stall, 0);
    check("reset_ifid_flush", ifid_flush, 1);

    do_reset();
    repeat (10) step();
    check("idle_pc_en", pc_en, 1);
    check("idle_exmem_en", exmem_en, 1);
    check("idle_pc_sel", pc_sel, 0);
    check("idle_stall_cnt", stall_cnt, 0);
    check("idle_flush_cnt", flush_cnt, 0);

    set_lu(5'd8); #1;
    check("lu_pc_en", pc_en, 0);
    check("lu_ifid_en", ifid_en, 0);
    check("lu_idex_flush", idex_flush, 1);
    check("lu_stall", stall, 1);
    step(); idle(); #1;
    check("lu_after_stall", stall, 0);
    check("lu_stall_cnt", stall_cnt, 1);
    set_lu(5'd0); id_rs = 5'd0; #1;
    check("lu_r0_stall", stall, 0);
    step(); idle(); #1;
    check("lu_r0_stall_cnt", stall_cnt, 1);

    do_reset();
    set_lu(5'd8); id_jump = 1; ex_branch_taken = 1; #1;
    check("br_pc_sel", pc_sel, 1);
    check("br_ifid_flush", ifid_flush, 1);
    check("br_idex_flush", idex_flush, 1);
    check("br_stall", stall, 0);
    step(); idle(); #1;
    check("br_flush_cnt", flush_cnt, 1);
    id_jump = 1; #1;
    check("jmp_pc_sel", pc_sel, 2);
    step(); idle(); #1;
    check("jmp_flush_cnt", flush_cnt, 2);

    do_reset();
    mem_req = 1; dmem_ready = 0; #1;
    check("frz_stall", stall, 1);
    check("frz_bubble", memwb_bubble, 1);
    step(); step(); step();
    dmem_ready = 1; #1;
    check("frz_done_pc_en", pc_en, 1);
    check("frz_stall_cnt", stall_cnt, 3);
    step(); idle(); #1;
    check("frz_run_pc_en", pc_en, 1);
    check("frz_mem_err", mem_err, 0);

    do_reset();
    mem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("to_stall", stall, 1);
      check("to_mem_err_pre", mem_err, 0);
      step();
    end
    idle(); #1;
    check("to_mem_err", mem_err, 1);
    check("to_err_pc_en", pc_en, 0);
    check("to_err_stall", stall, 1);
    check("to_stall_cnt", stall_cnt, 5);
    step(); step(); #1;
    check("to_err_held", mem_err, 1);
    check("to_cnt_frozen", stall_cnt, 5);
    rst_n = 0; #1;
    check("to_rst_mem_err", mem_err, 0);
    check("to_rst_idex_flush", idex_flush, 1);
    step(); rst_n = 1; #1;
    check("to_run_pc_en", pc_en, 1);

    do_reset();
    set_lu(5'd8);
    repeat (20) step();
    check("sat_stall_cnt", stall_cnt, 15);
    idle();

    do_reset();
    begin
      int mode = 0;
      for (int c = 0; c < 4000; c++) begin
        if (c % 100 == 0) mode = $urandom_range(0, 2);
        rst_n = ($urandom_range(0, 149) != 0);
        id_rs = 5'($urandom_range(0, 3));
        id_rt = 5'($urandom_range(0, 3));
        ex_rd = 5'($urandom_range(0, 3));
        id_uses_rs = $urandom_range(0, 1) != 0;
        id_uses_rt = $urandom_range(0, 1) != 0;
        id_jump = $urandom_range(0, 4) == 0;
        ex_memtoreg = $urandom_range(0, 2) == 0;
        ex_branch_taken = $urandom_range(0, 5) == 0;
        if (mode == 2) begin
          mem_req = $urandom_range(0, 7) != 0;
          dmem_ready = $urandom_range(0, 7) == 0;
        end else begin
          mem_req = $urandom_range(0, 2) == 0;
          dmem_ready = $urandom_range(0, 3) != 0;
        end
        step();
      end
    end

    idle(); rst_n = 1;
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall sequencer for the five-stage MIPS pipeline. It detects load-use hazards, applies branch and jump redirection and flushes, and freezes the whole pipeline while the data memory holds off a request. Its outputs drive the PC, the IF/ID, ID/EX, EX/MEM and MEM/WB register enables and flushes, and the decoder's `stall` input. It also keeps saturating stall and flush performance counters.

## Interface
- `TIMEOUT`, 16: number of MEM_WAIT cycles without `dmem_ready` before the block declares a fatal memory error (≥1).
- `CNT_W`, 16: width of the performance counters.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `id_rs`, `id_rt`  in  5 each  source register fields of the instruction in ID.
- `id_uses_rs`, `id_uses_rt`  in  1 each  the ID instruction reads rs / rt.
- `id_jump`  in  1  the ID instruction is J.
- `ex_memtoreg`  in  1  the EX instruction is lw.
- `ex_rd`  in  5  destination register of the EX instruction.
- `ex_branch_taken`  in  1  beq/bne resolved taken in EX.
- `mem_req`  in  1  the MEM instruction accesses data memory (lw/sw).
- `dmem_ready`  in  1  data memory completes the access this cycle.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`  out  1 each  register write enables.
- `ifid_flush`, `idex_flush`, `memwb_bubble`  out  1 each  load a NOP/bubble at the next edge.
- `pc_sel`  out  2  00 = PC+4, 01 = branch target, 10 = jump target.
- `stall`  out  1  to the decoder; suppresses control in the stalled instruction.
- `mem_err`  out  1  sticky; memory timeout occurred.
- `stall_cnt`, `flush_cnt`  out  CNT_W each  saturating event counters.

## Operation
- FSM states: RUN, MEM_WAIT, ERROR. Reset state is RUN. Reset also clears `wait_cnt`, `mem_err`, `stall_cnt` and `flush_cnt` to 0.
- Outputs are combinational from the state and the inputs.
- While `rst_n`=0, outputs are forced regardless of state:
  - all enables 0;
  - `ifid_flush`=`idex_flush`=`memwb_bubble`=1;
  - `pc_sel`=00;
  - `stall`=0.
- **freeze** = (state RUN or MEM_WAIT) && `mem_req` && !`dmem_ready`.
  - Forces `pc_en`=`ifid_en`=`idex_en`=`exmem_en`=0, `memwb_bubble`=1 and `stall`=1.
  - Flushes are 0 and `pc_sel`=00.
  - Highest priority: branch and load-use logic are ignored during freeze.
- **Default (no freeze):** all enables 1, flushes/bubble 0, `pc_sel`=00.
- **Branch**, `ex_branch_taken`=1: `pc_sel`=01, `ifid_flush`=1, `idex_flush`=1. This overrides load-use and jump, because both of those instructions are wrong-path.
- **Load-use**: `ex_memtoreg` && `ex_rd`≠0 && ((`id_uses_rs` && `id_rs`==`ex_rd`) || (`id_uses_rt` && `id_rt`==`ex_rd`)).
  - Sets `pc_en`=0, `ifid_en`=0, `idex_flush`=1, `stall`=1.
  - Lasts exactly one cycle; forwarding covers the following cycle.
  - A simultaneous `id_jump` is ignored; the jump redirects when it is re-presented.
- **Jump**, `id_jump`=1 with no branch and no load-use: `pc_sel`=10, `ifid_flush`=1.
- **FSM transitions:**
  - RUN→MEM_WAIT on freeze; `wait_cnt` is set to 0.
  - In MEM_WAIT with `dmem_ready`=1: outputs are exactly as in RUN with no freeze (branch/load-use/jump decoded normally); next state RUN.
  - In MEM_WAIT with `dmem_ready`=0: if `wait_cnt`==TIMEOUT-1, next state ERROR and `mem_err` is set; otherwise `wait_cnt`+1.
  - ERROR: all enables 0, `memwb_bubble`=1, `stall`=1, counters frozen. Exit is by reset only.
  - `mem_req`=0 in MEM_WAIT is treated as ready (returns to RUN).
- **Counters:**
  - `stall_cnt`+1 per cycle with `stall`=1 in RUN/MEM_WAIT.
  - `flush_cnt`+1 per cycle with `ifid_flush`=1.
  - Both saturate at all-ones.

## Timing
- Zero-latency hazard response: outputs are valid in the same cycle as the inputs; downstream registers act at the next rising edge.
- Load-use costs exactly one bubble cycle. Taken branch costs two flushed slots; jump costs one.
- A timeout freezes the pipeline for 1+TIMEOUT cycles in total (entry cycle + TIMEOUT MEM_WAIT cycles), then ERROR.
- Counter and FSM updates land on the edge that ends the qualifying cycle.
- Asserting reset mid-MEM_WAIT or in ERROR returns immediately to RUN with forced reset outputs. `mem_err` clears.

## Test plan
- Reset then idle, no hazards: all enables 1, `pc_sel`=00, `stall_cnt`=`flush_cnt`=0 after 10 cycles.
- `ex_memtoreg`=1, `ex_rd`=8, `id_rs`=8, `id_uses_rs`=1 for one cycle → `pc_en`=`ifid_en`=0, `idex_flush`=1, `stall`=1 that cycle only, `stall_cnt`=1. Repeat with `ex_rd`=0 → no stall.
- `ex_branch_taken`=1 together with a load-use match and `id_jump`=1 → `pc_sel`=01, both flushes 1, `stall`=0, `flush_cnt`+1.
- `mem_req`=1, `dmem_ready` low 3 cycles then high → freeze for 3 cycles, state returns RUN, `stall_cnt`=3, then default outputs.
- TIMEOUT=4, `mem_req`=1, `dmem_ready` held 0 → freeze 5 cycles, then ERROR with `mem_err`=1 held. Deassert `rst_n` → RUN, `mem_err`=0.
- CNT_W=4, hold a load-use condition for 20 cycles → `stall_cnt` saturates at 15.
